// File: rtl/roce_gen_pkg.sv
// Shared definitions for the RoCEv2 test-payload generator and its receive-side checker.
package roce_gen_pkg;

  localparam logic [1:0] MODE_CNT   = 2'd0;
  localparam logic [1:0] MODE_PRBS  = 2'd1;
  localparam logic [1:0] MODE_CONST = 2'd2;

  // x^31 + x^28 + 1, expressed as 0-based state bit positions
  localparam int PRBS_TAP_A = 30;
  localparam int PRBS_TAP_B = 27;

  localparam int MAX_KEEP = 64;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_FIN
  } gen_state_e;

  // Low 'count' bits set; callers cast the result down to their own KEEP_WIDTH.
  function automatic logic [MAX_KEEP-1:0] count2keep(input logic [6:0] count);
    logic [MAX_KEEP-1:0] k;
    k = '0;
    for (int i = 0; i < MAX_KEEP; i++) begin
      k[i] = (i < int'(count));
    end
    return k;
  endfunction

endpackage

// File: rtl/roce_prbs31_step.sv
// Combinational PRBS31 advance by DATA_WIDTH bits; data bit 0 is the first bit generated.
module roce_prbs31_step
  import roce_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  logic [30:0]           state,
  output logic [30:0]           next_state,
  output logic [DATA_WIDTH-1:0] data
);

  logic [30:0] s;
  logic        fb;

  always_comb begin
    s    = state;
    fb   = 1'b0;
    data = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      fb      = s[PRBS_TAP_A] ^ s[PRBS_TAP_B];
      data[i] = fb;
      s       = {s[29:0], fb};
    end
    next_state = s;
  end

endmodule

// File: rtl/roce_payload_gen.sv
// AXI-Stream test-payload source: counter / PRBS31 / constant data, repeatable transfers, abort.
// Stream handshake: a beat moves on tvalid && tready; tvalid never drops without a handshake.
module roce_payload_gen
  import roce_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           cfg_length,
  input  logic [1:0]            cfg_mode,
  input  logic [31:0]           cfg_seed,
  input  logic [15:0]           cfg_repeat,
  input  logic                  start,
  input  logic                  abort,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           xfer_count
);

  localparam int          LANES64 = DATA_WIDTH / 64;
  localparam int          LANES32 = DATA_WIDTH / 32;
  localparam logic [31:0] KW32    = 32'(KEEP_WIDTH);

  gen_state_e state, state_nxt;

  logic                  start_d1, start_d2;
  logic [31:0]           len_r, seed_r, off, lane_off;
  logic [1:0]            mode_r;
  logic [15:0]           rep_r, cnt_inc;
  logic [30:0]           lfsr, prbs_next;
  logic [DATA_WIDTH-1:0] prbs_data, pattern;
  logic [KEEP_WIDTH-1:0] last_keep;
  logic [6:0]            rem;
  logic                  abort_pend, start_rise, run, hs, natural_last, eff_last;

  roce_prbs31_step #(.DATA_WIDTH(DATA_WIDTH)) u_prbs (
    .state      (lfsr),
    .next_state (prbs_next),
    .data       (prbs_data)
  );

  assign start_rise   = start_d1 & ~start_d2;
  assign run          = (state == ST_RUN);
  assign hs           = run & m_axis_tready;
  // 33-bit compare so a length near 2^32 cannot wrap the offset sum
  assign natural_last = ({1'b0, off} + {1'b0, KW32}) >= {1'b0, len_r};
  assign eff_last     = natural_last | abort_pend;
  assign rem          = 7'(len_r % KW32);
  assign last_keep    = (rem == 7'd0) ? '1 : KEEP_WIDTH'(count2keep(rem));
  assign cnt_inc      = (xfer_count == 16'hFFFF) ? xfer_count : xfer_count + 16'd1;

  always_comb begin
    pattern  = '0;
    lane_off = '0;
    case (mode_r)
      MODE_PRBS:  pattern = prbs_data;
      MODE_CONST: begin
        for (int i = 0; i < LANES32; i++) pattern[32*i +: 32] = seed_r;
      end
      default: begin
        for (int j = 0; j < LANES64; j++) begin
          lane_off            = off + 32'(8 * j);
          pattern[64*j +: 64] = {~lane_off, lane_off};
        end
      end
    endcase
  end

  assign m_axis_tvalid = run;
  assign m_axis_tdata  = run ? pattern : '0;
  assign m_axis_tkeep  = run ? (natural_last ? last_keep : '1) : '0;
  assign m_axis_tlast  = run & eff_last;
  assign m_axis_tuser  = run & abort_pend;
  assign busy          = (state != ST_IDLE);
  assign done          = (state == ST_FIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_rise) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = (cfg_length == 32'd0) ? ST_FIN : ST_RUN;
      ST_RUN: begin
        if (hs && eff_last && (abort_pend || cnt_inc == rep_r)) state_nxt = ST_FIN;
      end
      ST_FIN:  state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_d1   <= 1'b0;
      start_d2   <= 1'b0;
      len_r      <= '0;
      mode_r     <= '0;
      seed_r     <= '0;
      rep_r      <= '0;
      off        <= '0;
      lfsr       <= 31'd1;
      abort_pend <= 1'b0;
      xfer_count <= '0;
    end else begin
      start_d1 <= start;
      start_d2 <= start_d1;
      case (state)
        ST_LOAD: begin
          len_r      <= cfg_length;
          mode_r     <= cfg_mode;
          seed_r     <= cfg_seed;
          rep_r      <= (cfg_repeat == 16'd0) ? 16'd1 : cfg_repeat;
          off        <= '0;
          xfer_count <= '0;
          abort_pend <= 1'b0;
          lfsr       <= (cfg_seed[30:0] == 31'd0) ? 31'd1 : cfg_seed[30:0];
        end
        ST_RUN: begin
          if (abort) abort_pend <= 1'b1;
          if (hs) begin
            lfsr <= prbs_next;
            if (eff_last) begin
              xfer_count <= cnt_inc;
              off        <= '0;
            end else begin
              off <= off + KW32;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_roce_payload_gen.sv
// Directed bench for roce_payload_gen: 64-bit and 256-bit instances, hand-computed beats.
module tb_roce_payload_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] cfg_length, cfg_seed;
  logic [1:0]  cfg_mode;
  logic [15:0] cfg_repeat;
  logic        start, abort, tready_a, tready_b, sel_b;

  always #5 clk = ~clk;

  logic [63:0]  a_tdata;
  logic [7:0]   a_tkeep;
  logic         a_tvalid, a_tlast, a_tuser, a_busy, a_done;
  logic [15:0]  a_xfer;
  logic [255:0] b_tdata;
  logic [31:0]  b_tkeep;
  logic         b_tvalid, b_tlast, b_tuser, b_busy, b_done;
  logic [15:0]  b_xfer;

  roce_payload_gen #(.DATA_WIDTH(64)) dut_a (
    .clk(clk), .rst_n(rst_n), .cfg_length(cfg_length), .cfg_mode(cfg_mode),
    .cfg_seed(cfg_seed), .cfg_repeat(cfg_repeat), .start(start), .abort(abort),
    .m_axis_tdata(a_tdata), .m_axis_tkeep(a_tkeep), .m_axis_tvalid(a_tvalid),
    .m_axis_tready(tready_a), .m_axis_tlast(a_tlast), .m_axis_tuser(a_tuser),
    .busy(a_busy), .done(a_done), .xfer_count(a_xfer)
  );

  roce_payload_gen #(.DATA_WIDTH(256)) dut_b (
    .clk(clk), .rst_n(rst_n), .cfg_length(cfg_length), .cfg_mode(cfg_mode),
    .cfg_seed(cfg_seed), .cfg_repeat(cfg_repeat), .start(start), .abort(abort),
    .m_axis_tdata(b_tdata), .m_axis_tkeep(b_tkeep), .m_axis_tvalid(b_tvalid),
    .m_axis_tready(tready_b), .m_axis_tlast(b_tlast), .m_axis_tuser(b_tuser),
    .busy(b_busy), .done(b_done), .xfer_count(b_xfer)
  );

  logic [255:0] mon_tdata;
  logic [31:0]  mon_tkeep;
  logic         mon_tvalid, mon_tlast, mon_tuser, mon_busy, mon_done;
  logic [15:0]  mon_xfer;

  always_comb begin
    if (sel_b) begin
      mon_tdata = b_tdata;  mon_tkeep = b_tkeep;  mon_tvalid = b_tvalid;
      mon_tlast = b_tlast;  mon_tuser = b_tuser;  mon_busy = b_busy;
      mon_done  = b_done;   mon_xfer  = b_xfer;
    end else begin
      mon_tdata = {192'b0, a_tdata};  mon_tkeep = {24'b0, a_tkeep};  mon_tvalid = a_tvalid;
      mon_tlast = a_tlast;  mon_tuser = a_tuser;  mon_busy = a_busy;
      mon_done  = a_done;   mon_xfer  = a_xfer;
    end
  end

  // scoreboard
  int n_cmp = 0;
  int n_mis = 0;
  logic [255:0] exp_q[$];
  logic [31:0]  exp_k[$];
  logic         exp_l[$], exp_u[$];
  logic [255:0] cap_d[$];
  logic [31:0]  cap_k[$];
  logic         cap_l[$], cap_u[$];
  int busy_cyc, done_c, last_hs_c, first_v_c, n_valid;
  logic job_fin;

  task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [255:0] d, input logic [31:0] k, input logic l, input logic u);
    exp_q.push_back(d); exp_k.push_back(k); exp_l.push_back(l); exp_u.push_back(u);
  endtask

  task automatic check_beats(input string tag);
    int n;
    check_eq({tag, "_beats"}, cap_d.size(), exp_q.size());
    n = (cap_d.size() < exp_q.size()) ? cap_d.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s_data%0d", tag, i), cap_d[i], exp_q[i]);
      check_eq($sformatf("%s_keep%0d", tag, i), cap_k[i], exp_k[i]);
      check_eq($sformatf("%s_last%0d", tag, i), cap_l[i], exp_l[i]);
      check_eq($sformatf("%s_user%0d", tag, i), cap_u[i], exp_u[i]);
    end
    exp_q.delete(); exp_k.delete(); exp_l.delete(); exp_u.delete();
  endtask

  // Fibonacci PRBS31 reference, x^31 + x^28 + 1, first generated bit in bit 0
  function automatic logic [127:0] prbs_bits(input logic [30:0] seed);
    logic [30:0]  s;
    logic [127:0] r;
    logic         fb;
    s = seed;
    r = '0;
    for (int i = 0; i < 128; i++) begin
      fb   = s[30] ^ s[27];
      r[i] = fb;
      s    = {s[29:0], fb};
    end
    return r;
  endfunction

  task automatic run_job(input logic use_b, input logic [31:0] len, input logic [1:0] mode,
                         input logic [31:0] seed, input logic [15:0] rep, input int pct,
                         input int abort_at, input int reset_at);
    logic [255:0] pd;
    logic [31:0]  pk;
    logic         pl, pu, prev_stall, rdy;
    int           phase;
    for (int k = 0; k < 3000 && (a_busy || b_busy); k++) @(negedge clk);
    cap_d.delete(); cap_k.delete(); cap_l.delete(); cap_u.delete();
    busy_cyc = 0; done_c = -1; last_hs_c = -1; first_v_c = -1; n_valid = 0;
    job_fin = 1'b0; phase = 0; prev_stall = 1'b0;
    pd = '0; pk = '0; pl = 1'b0; pu = 1'b0;
    sel_b = use_b; cfg_length = len; cfg_mode = mode; cfg_seed = seed; cfg_repeat = rep;
    abort = 1'b0; tready_a = 1'b1; tready_b = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 3000 && !job_fin; c++) begin
      if (c > 0) @(negedge clk);
      rdy   = ($urandom_range(99) < pct);
      abort = 1'b0;
      if (abort_at >= 0 && cap_d.size() == abort_at && mon_tvalid && phase < 2) begin
        rdy = 1'b0;
        if (phase == 0) abort = 1'b1;
        phase++;
      end
      if (reset_at >= 0 && cap_d.size() == reset_at) begin
        check_eq("pre_reset_xfer", mon_xfer, 16'd1);
        check_eq("pre_reset_valid", mon_tvalid, 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_tvalid", mon_tvalid, 1'b0);
        check_eq("rst_tdata", mon_tdata, 256'd0);
        check_eq("rst_tkeep", mon_tkeep, 32'd0);
        check_eq("rst_tlast", {mon_tlast, mon_tuser}, 2'b00);
        check_eq("rst_busy_done", {mon_busy, mon_done}, 2'b00);
        check_eq("rst_xfer", mon_xfer, 16'd0);
        @(negedge clk); rst_n = 1'b1;
        job_fin = 1'b1;
      end else begin
        if (use_b) tready_b = rdy; else tready_a = rdy;
        if (mon_busy) busy_cyc++;
        if (mon_tvalid) begin
          n_valid++;
          if (first_v_c < 0) first_v_c = c;
          if (prev_stall && abort_at < 0) begin
            check_eq("stall_data", mon_tdata, pd);
            check_eq("stall_ctl", {mon_tkeep, mon_tlast, mon_tuser}, {pk, pl, pu});
          end
          if (rdy) begin
            cap_d.push_back(mon_tdata); cap_k.push_back(mon_tkeep);
            cap_l.push_back(mon_tlast); cap_u.push_back(mon_tuser);
            last_hs_c = c;
          end
          prev_stall = !rdy;
          pd = mon_tdata; pk = mon_tkeep; pl = mon_tlast; pu = mon_tuser;
        end else begin
          prev_stall = 1'b0;
        end
        if (mon_done) begin
          done_c  = c;
          job_fin = 1'b1;
        end
      end
    end
    tready_a = 1'b1; tready_b = 1'b1; abort = 1'b0;
    if (reset_at < 0) check_eq("done_seen", job_fin, 1'b1);
  endtask

  task automatic counter20_job(input string tag);
    push_exp(64'hFFFFFFFF_00000000, 32'hFF, 1'b0, 1'b0);
    push_exp(64'hFFFFFFF7_00000008, 32'hFF, 1'b0, 1'b0);
    push_exp(64'hFFFFFFEF_00000010, 32'h0F, 1'b1, 1'b0);
    run_job(1'b0, 32'd20, 2'd0, 32'd0, 16'd1, 100, -1, -1);
    check_beats(tag);
    check_eq({tag, "_first_valid"}, first_v_c, 2);
    check_eq({tag, "_done_lat"}, done_c - last_hs_c, 1);
    check_eq({tag, "_xfer"}, mon_xfer, 16'd1);
  endtask

  logic [127:0] pr;
  logic [255:0] b0, b1;

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; sel_b = 1'b0;
    cfg_length = '0; cfg_mode = '0; cfg_seed = '0; cfg_repeat = '0;
    tready_a = 1'b1; tready_b = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("reset_tvalid", {a_tvalid, b_tvalid}, 2'b00);
    check_eq("reset_tdata", a_tdata, 64'd0);
    check_eq("reset_status", {a_busy, a_done, a_tlast, a_tuser, a_tkeep}, 12'd0);
    check_eq("reset_xfer", a_xfer, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);

    counter20_job("cnt20");

    // zero length: LOAD then FIN, no beats
    run_job(1'b0, 32'd0, 2'd0, 32'd0, 16'd1, 100, -1, -1);
    check_beats("len0");
    check_eq("len0_valid", n_valid, 0);
    check_eq("len0_busy", busy_cyc, 2);
    check_eq("len0_xfer", mon_xfer, 16'd0);

    // 256-bit, 3 repeats of 64 bytes under random stall
    b0 = 256'hFFFFFFE7_00000018_FFFFFFEF_00000010_FFFFFFF7_00000008_FFFFFFFF_00000000;
    b1 = 256'hFFFFFFC7_00000038_FFFFFFCF_00000030_FFFFFFD7_00000028_FFFFFFDF_00000020;
    for (int t = 0; t < 3; t++) begin
      push_exp(b0, 32'hFFFFFFFF, 1'b0, 1'b0);
      push_exp(b1, 32'hFFFFFFFF, 1'b1, 1'b0);
    end
    run_job(1'b1, 32'd64, 2'd0, 32'd0, 16'd3, 50, -1, -1);
    check_beats("rep3");
    check_eq("rep3_xfer", mon_xfer, 16'd3);

    // PRBS31 seed 1, then seed 0 (replaced by 1)
    pr = prbs_bits(31'd1);
    push_exp(pr[63:0], 32'hFF, 1'b0, 1'b0);
    push_exp(pr[127:64], 32'hFF, 1'b1, 1'b0);
    run_job(1'b0, 32'd16, 2'd1, 32'd1, 16'd1, 100, -1, -1);
    check_beats("prbs_s1");
    push_exp(pr[63:0], 32'hFF, 1'b0, 1'b0);
    push_exp(pr[127:64], 32'hFF, 1'b1, 1'b0);
    run_job(1'b0, 32'd16, 2'd1, 32'd0, 16'd1, 100, -1, -1);
    check_beats("prbs_s0");
    // LFSR continues across repeats; seed bit 31 is ignored
    push_exp(pr[63:0], 32'hFF, 1'b1, 1'b0);
    push_exp(pr[127:64], 32'hFF, 1'b1, 1'b0);
    run_job(1'b0, 32'd8, 2'd1, 32'h80000001, 16'd2, 100, -1, -1);
    check_beats("prbs_rep");
    check_eq("prbs_rep_xfer", mon_xfer, 16'd2);

    // constant pattern, and mode 3 falling back to counter
    push_exp(64'hDEADBEEF_DEADBEEF, 32'hFF, 1'b0, 1'b0);
    push_exp(64'hDEADBEEF_DEADBEEF, 32'h03, 1'b1, 1'b0);
    run_job(1'b0, 32'd10, 2'd2, 32'hDEADBEEF, 16'd0, 100, -1, -1);
    check_beats("const");
    check_eq("const_xfer", mon_xfer, 16'd1);
    push_exp(64'hFFFFFFFF_00000000, 32'hFF, 1'b1, 1'b0);
    run_job(1'b0, 32'd8, 2'd3, 32'd0, 16'd1, 100, -1, -1);
    check_beats("mode3");

    // abort during a stalled beat 5 of a 100-byte job
    push_exp(64'hFFFFFFFF_00000000, 32'hFF, 1'b0, 1'b0);
    push_exp(64'hFFFFFFF7_00000008, 32'hFF, 1'b0, 1'b0);
    push_exp(64'hFFFFFFEF_00000010, 32'hFF, 1'b0, 1'b0);
    push_exp(64'hFFFFFFE7_00000018, 32'hFF, 1'b0, 1'b0);
    push_exp(64'hFFFFFFDF_00000020, 32'hFF, 1'b1, 1'b1);
    run_job(1'b0, 32'd100, 2'd0, 32'd0, 16'd1, 100, 4, -1);
    check_beats("abort");
    check_eq("abort_done_lat", done_c - last_hs_c, 1);
    check_eq("abort_xfer", mon_xfer, 16'd1);

    // async reset mid-run, then a clean job from offset 0
    run_job(1'b0, 32'd16, 2'd0, 32'd0, 16'd3, 100, -1, 3);
    counter20_job("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
